// File: rtl/transformer_pkg.sv
// Shared types for the transform setup receive path: matrix, triangle,
// setup beat payload, FIFO entry and the receiver FSM state encoding.
package transformer_pkg;

    localparam int TSRX_FIFO_DEPTH_DEFAULT = 4;

    // 3x4 affine transform, row-major, 16-bit fixed point elements.
    typedef struct packed {
        logic [11:0][15:0] m;
    } transform_t;

    // Three vertices of x/y/z, 16-bit fixed point.
    typedef struct packed {
        logic [2:0][2:0][15:0] v;
    } triangle_t;

    // One setup beat from the frame driver.
    typedef struct packed {
        triangle_t  triangle;
        transform_t model_transform;
        logic       model_transform_valid;
        transform_t camera_transform;
        logic       camera_transform_valid;
    } transform_setup_t;

    // What gets buffered per triangle: geometry plus its model transform.
    typedef struct packed {
        triangle_t  triangle;
        transform_t model_transform;
    } setup_fifo_entry_t;

    typedef enum logic [1:0] {
        WAIT_CAM = 2'd0,
        STREAM   = 2'd1,
        DRAIN    = 2'd2,
        END      = 2'd3
    } tsrx_state_t;

endpackage

// File: rtl/transform_setup_rx_if.sv
// Bus bundle for transform_setup_rx: setup beat input, FIFO head output,
// camera register and frame status. Statistics ports exist only when
// TSRX_STATS_EN is defined.
interface transform_setup_rx_if;
    import transformer_pkg::*;

    logic             in_valid;
    logic             in_ready;
    transform_setup_t transform_setup;
    logic             frame_feed_done;
    logic             out_valid;
    logic             out_ready;
    triangle_t        out_triangle;
    transform_t       out_model_transform;
    transform_t       camera_transform;
    logic             camera_loaded;
    logic             frame_end;
`ifdef TSRX_STATS_EN
    logic [15:0]      tri_count;
    logic [15:0]      drop_count;
`endif

`ifdef TSRX_STATS_EN
    modport slave (
        input  in_valid, transform_setup, frame_feed_done, out_ready,
        output in_ready, out_valid, out_triangle, out_model_transform,
        output camera_transform, camera_loaded, frame_end,
        output tri_count, drop_count
    );
    modport master (
        output in_valid, transform_setup, frame_feed_done, out_ready,
        input  in_ready, out_valid, out_triangle, out_model_transform,
        input  camera_transform, camera_loaded, frame_end,
        input  tri_count, drop_count
    );
`else
    modport slave (
        input  in_valid, transform_setup, frame_feed_done, out_ready,
        output in_ready, out_valid, out_triangle, out_model_transform,
        output camera_transform, camera_loaded, frame_end
    );
    modport master (
        output in_valid, transform_setup, frame_feed_done, out_ready,
        input  in_ready, out_valid, out_triangle, out_model_transform,
        input  camera_transform, camera_loaded, frame_end
    );
`endif

endinterface

// File: rtl/setup_fifo.sv
// Synchronous FIFO with a registered head output. The head register is
// refreshed on every push/pop so the output never depends combinationally
// on wr_data. A push into a full FIFO succeeds when a pop happens in the
// same cycle.
module setup_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_inc;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             push, pop;

    assign pop        = rd_en && (count_reg != '0);
    assign push       = wr_en && ((count_reg != FULL_CNT) || pop);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

    // Next occupancy and next head value; the head bypasses wr_data when
    // the pushed entry is the only one left after this cycle.
    always_comb begin
        count_next = count_reg;
        head_next  = head_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
        if (pop) begin
            if (count_reg == CW'(1)) begin
                if (push) head_next = wr_data;
            end else begin
                head_next = mem[rd_ptr_inc];
            end
        end else if ((count_reg == '0) && push) begin
            head_next = wr_data;
        end
    end

    // Storage array, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= wr_data;
    end

    // Pointers, count and head register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_inc;
            count_reg <= count_next;
            head_reg  <= head_next;
        end
    end

    assign rd_data = head_reg;
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);

endmodule

// File: rtl/transform_setup_rx.sv
// Receives setup beats from the frame driver, latches the per-frame camera
// transform and buffers {triangle, model transform} entries for the
// transform datapath. A camera change is only taken while the FIFO is
// empty, so queued triangles always see the camera they were issued under.
// Optional TSRX_STATS_EN adds tri_count / drop_count outputs.
module transform_setup_rx
    import transformer_pkg::*;
#(
    parameter int FIFO_DEPTH = TSRX_FIFO_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    transform_setup_rx_if.slave  bus
);
    tsrx_state_t       state_reg, state_next;
    logic              ffd_q_reg;
    transform_t        camera_reg;
    logic              camera_loaded_reg;

    logic              cam_flag, mdl_flag;
    logic              fifo_empty, fifo_full, room;
    logic              in_ready_int, frame_end_int;
    logic              accept, push, cam_load, ffd_rise;
    setup_fifo_entry_t wr_entry, rd_entry;

    assign cam_flag = bus.transform_setup.camera_transform_valid;
    assign mdl_flag = bus.transform_setup.model_transform_valid;
    // A full FIFO still has room when the head leaves this cycle.
    assign room     = !fifo_full || bus.out_ready;
    assign ffd_rise = bus.frame_feed_done && !ffd_q_reg;

    assign accept   = bus.in_valid && in_ready_int;
    assign push     = accept && mdl_flag;
    assign cam_load = accept && cam_flag;

    assign wr_entry.triangle        = bus.transform_setup.triangle;
    assign wr_entry.model_transform = bus.transform_setup.model_transform;

    setup_fifo #(
        .WIDTH ($bits(setup_fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (bus.out_ready),
        .rd_data (rd_entry),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // FSM state register plus the registered copy of frame_feed_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= WAIT_CAM;
            ffd_q_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ffd_q_reg <= bus.frame_feed_done;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT_CAM: if (cam_load) state_next = STREAM;
            STREAM:   if (ffd_rise) state_next = DRAIN;
            DRAIN:    if (fifo_empty) state_next = END;
            END:      state_next = WAIT_CAM;
            default:  state_next = WAIT_CAM;
        endcase
    end

    // FSM outputs: beat acceptance and the end-of-frame pulse.
    always_comb begin
        in_ready_int  = 1'b0;
        frame_end_int = 1'b0;
        case (state_reg)
            WAIT_CAM: in_ready_int = cam_flag && room;
            STREAM:   in_ready_int = cam_flag ? fifo_empty : room;
            END:      frame_end_int = 1'b1;
            default: begin
                in_ready_int  = 1'b0;
                frame_end_int = 1'b0;
            end
        endcase
    end

    // Camera register and its loaded flag; the flag drops after frame_end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            camera_reg        <= '0;
            camera_loaded_reg <= 1'b0;
        end else begin
            if (cam_load) begin
                camera_reg        <= bus.transform_setup.camera_transform;
                camera_loaded_reg <= 1'b1;
            end else if (state_reg == END) begin
                camera_loaded_reg <= 1'b0;
            end
        end
    end

`ifdef TSRX_STATS_EN
    logic        pop, drop;
    logic [15:0] tri_count_reg, drop_count_reg;

    assign pop  = bus.out_ready && !fifo_empty;
    assign drop = accept && !cam_flag && !mdl_flag;

    // Per-frame dequeue count and sticky saturating drop count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tri_count_reg  <= '0;
            drop_count_reg <= '0;
        end else begin
            if (state_reg == END)
                tri_count_reg <= '0;
            else if (pop)
                tri_count_reg <= tri_count_reg + 16'd1;
            if (drop && (drop_count_reg != 16'hFFFF))
                drop_count_reg <= drop_count_reg + 16'd1;
        end
    end

    assign bus.tri_count  = tri_count_reg;
    assign bus.drop_count = drop_count_reg;
`endif

    assign bus.in_ready            = in_ready_int;
    assign bus.out_valid           = !fifo_empty;
    assign bus.out_triangle        = rd_entry.triangle;
    assign bus.out_model_transform = rd_entry.model_transform;
    assign bus.camera_transform    = camera_reg;
    assign bus.camera_loaded       = camera_loaded_reg;
    assign bus.frame_end           = frame_end_int;

endmodule
